cond_exec_sequencer: RTL and testbench
======================================

Name: cond_exec_sequencer

Overview:
Sequences conditional execution across the ID->EXE boundary of the ARM pipeline. Owns the architectural NZCV status register and evaluates each ID-stage condition field against it, with optional forwarding from the EXE-stage ALU. It detects flag read-after-write hazards and inserts EXE bubbles when forwarding is disabled. It also applies branch flush and external freeze, and counts flag-stall cycles.

Parameters:
FWD_EN, 1, 1 = bypass exe_alu_flags to the ID condition evaluation; 0 = stall one cycle on a flag hazard
CNT_W, 16, width of the saturating flag-stall counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
id_valid  input  1  instruction present in ID
id_cond  input  4  ARM condition field of the ID instruction (bits 31:28)
id_set_flags  input  1  ID instruction has S bit set
exe_alu_flags  input  4  NZCV produced by the ALU for the EXE instruction, {N,Z,C,V}
freeze  input  1  external pipeline freeze (memory/hazard unit)
flush  input  1  taken branch in EXE; kill the ID instruction
id_exec  output  1  ID instruction passes its condition and will enter EXE as executed
flag_stall  output  1  ID must hold; EXE receives a bubble
exe_exec  output  1  registered: EXE instruction is executed
exe_set_flags  output  1  registered: EXE instruction will write NZCV
status  output  4  architectural NZCV register
stall_cnt  output  CNT_W  saturating count of flag_stall cycles

Behaviour:
- Reset (rst=0, async): status=4'b0000, exe_exec=0, exe_set_flags=0, stall_cnt=0. Combinational outputs follow inputs.
- Flag source for evaluation: src = exe_alu_flags when FWD_EN=1 & exe_exec & exe_set_flags; otherwise src = status.
- cond_pass, using src:
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N.
  - 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: ~Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- flag_stall = (FWD_EN==0) & id_valid & ~flush & (id_cond!=4'd14) & exe_exec & exe_set_flags. AL instructions never stall.
- id_exec = id_valid & cond_pass & ~flush & ~flag_stall & ~freeze.
- EXE register update, in priority order each edge:
  1. freeze=1: exe_exec, exe_set_flags and status all hold.
  2. Else, flush or flag_stall: insert a bubble (exe_exec<=0, exe_set_flags<=0).
  3. Else: exe_exec<=id_valid&cond_pass; exe_set_flags<=id_valid&cond_pass&id_set_flags.
- Status update: when ~freeze & exe_exec & exe_set_flags, status<=exe_alu_flags at the edge. A failed-condition instruction never writes status.
- Flush does not suppress the status write of the instruction already in EXE.
- Stall latency with FWD_EN=0: one bubble cycle. On the next cycle, status holds the new flags and flag_stall deasserts because exe_set_flags=0.
- With FWD_EN=1, flag_stall is constant 0 and back-to-back flag producer/consumer pairs run with zero bubbles.
- stall_cnt increments on each edge where flag_stall & ~freeze, and saturates at all-ones (no wrap).
- Simultaneous events:
  - freeze together with flush: freeze wins, nothing changes. flush must be re-presented after freeze drops.
  - flush together with a hazard: flush wins, no stall is counted.
- Reset asserted mid-stall clears the EXE bubble state and status immediately. No stall is pending after reset release.

Test Plan:
- Reset: hold rst=0, toggle inputs -> status=0, exe_exec=0, exe_set_flags=0, stall_cnt=0. Release, id_valid=1, id_cond=14 -> id_exec=1, exe_exec=1 next cycle.
- Condition table: for each status value 0..15 and id_cond 0..15 (status loaded via an S instruction) -> id_exec matches the table, e.g. status=4'b0110 (Z,C) gives HI=0, LS=1, EQ=1.
- Hazard with FWD_EN=0:
  - Cycle 0: SUBS (cond=14, S=1) with exe_alu_flags=4'b0100 when in EXE.
  - Cycle 1: BEQ (cond=0) in ID -> flag_stall=1, exe_exec=0 at cycle 2, status=4'b0100.
  - Cycle 2: id_exec=1, stall_cnt=1.
- Forwarding with FWD_EN=1: same sequence -> flag_stall=0 throughout, id_exec=1 in cycle 1 using exe_alu_flags.
- Flush and freeze:
  - flush=1 with a hazard present -> flag_stall=0, exe_exec=0 next cycle, status still updated by the EXE S instruction.
  - freeze=1 for 3 cycles -> status, exe_*, stall_cnt unchanged.
- Saturation: CNT_W=4, force 20 hazard cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/cond_exec_sequencer_if.sv
// ID/EXE conditional-execution bundle between the pipeline and the
// condition sequencer. The pipeline side is the master; the sequencer is
// the slave.
interface cond_exec_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [3:0]       id_cond;
   logic             id_set_flags;
   logic [3:0]       exe_alu_flags;
   logic             freeze;
   logic             flush;
   logic             id_exec;
   logic             flag_stall;
   logic             exe_exec;
   logic             exe_set_flags;
   logic [3:0]       status;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_cond, id_set_flags, exe_alu_flags, freeze, flush,
      input  id_exec, flag_stall, exe_exec, exe_set_flags, status, stall_cnt
   );

   modport slave (
      input  id_valid, id_cond, id_set_flags, exe_alu_flags, freeze, flush,
      output id_exec, flag_stall, exe_exec, exe_set_flags, status, stall_cnt
   );
endinterface

// File: rtl/cond_exec_sequencer.sv
// Conditional-execution sequencer for the ID->EXE boundary. Holds the
// architectural NZCV register, evaluates ID condition codes (optionally
// against forwarded ALU flags), inserts EXE bubbles on flag hazards when
// forwarding is off, and counts flag-stall cycles.
module cond_exec_sequencer #(
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input logic        clk,
   input logic        rst,
   cond_exec_if.slave bus
);

   localparam logic FWD = (FWD_EN != 0);

   logic             exe_exec_q, exe_exec_d;
   logic             exe_set_flags_q, exe_set_flags_d;
   logic [3:0]       status_q, status_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [3:0]       src;
   logic             flag_n, flag_z, flag_c, flag_v;
   logic             cond_pass;
   logic             exe_writes_flags;
   logic             flag_stall;
   logic             id_exec;

   // Pick the flag source: forwarded ALU flags when the EXE instruction is
   // about to write NZCV, otherwise the architectural register.
   always_comb begin
      exe_writes_flags = exe_exec_q & exe_set_flags_q;
      src              = status_q;
      if (FWD && exe_writes_flags) begin
         src = bus.exe_alu_flags;
      end
      {flag_n, flag_z, flag_c, flag_v} = src;
   end

   // Evaluate the ARM condition field against the selected flags.
   always_comb begin
      cond_pass = 1'b0;
      case (bus.id_cond)
         4'd0:    cond_pass = flag_z;
         4'd1:    cond_pass = ~flag_z;
         4'd2:    cond_pass = flag_c;
         4'd3:    cond_pass = ~flag_c;
         4'd4:    cond_pass = flag_n;
         4'd5:    cond_pass = ~flag_n;
         4'd6:    cond_pass = flag_v;
         4'd7:    cond_pass = ~flag_v;
         4'd8:    cond_pass = flag_c & ~flag_z;
         4'd9:    cond_pass = ~flag_c | flag_z;
         4'd10:   cond_pass = (flag_n == flag_v);
         4'd11:   cond_pass = (flag_n != flag_v);
         4'd12:   cond_pass = ~flag_z & (flag_n == flag_v);
         4'd13:   cond_pass = flag_z | (flag_n != flag_v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Hazard detection, issue decision and next-state for the EXE stage,
   // status register and stall counter. Flush beats a hazard so a killed
   // instruction never costs a counted stall.
   always_comb begin
      flag_stall = ~FWD & bus.id_valid & ~bus.flush &
                   (bus.id_cond != 4'd14) & exe_writes_flags;
      id_exec    = bus.id_valid & cond_pass & ~bus.flush & ~flag_stall &
                   ~bus.freeze;

      exe_exec_d      = exe_exec_q;
      exe_set_flags_d = exe_set_flags_q;
      status_d        = status_q;
      stall_cnt_d     = stall_cnt_q;

      if (!bus.freeze) begin
         // The EXE instruction retires its flags even when ID is flushed.
         if (exe_writes_flags) begin
            status_d = bus.exe_alu_flags;
         end
         if (bus.flush || flag_stall) begin
            exe_exec_d      = 1'b0;
            exe_set_flags_d = 1'b0;
         end else begin
            exe_exec_d      = bus.id_valid & cond_pass;
            exe_set_flags_d = bus.id_valid & cond_pass & bus.id_set_flags;
         end
         if (flag_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_exec_q      <= 1'b0;
         exe_set_flags_q <= 1'b0;
         status_q        <= 4'b0000;
         stall_cnt_q     <= '0;
      end else begin
         exe_exec_q      <= exe_exec_d;
         exe_set_flags_q <= exe_set_flags_d;
         status_q        <= status_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign bus.id_exec       = id_exec;
   assign bus.flag_stall    = flag_stall;
   assign bus.exe_exec      = exe_exec_q;
   assign bus.exe_set_flags = exe_set_flags_q;
   assign bus.status        = status_q;
   assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// Bench for cond_exec_sequencer: one instance without forwarding (4-bit
// counter, to reach saturation) and one with forwarding, driven by the same
// inputs and compared against a per-instance cycle model of the NZCV rules.
module tb_cond_exec_sequencer;

   logic clk;
   logic rst;
   logic id_valid;
   logic [3:0] id_cond;
   logic id_set_flags;
   logic [3:0] exe_alu_flags;
   logic freeze;
   logic flush;

   int total = 0;
   int bad   = 0;

   cond_exec_if #(.CNT_W(4))  if0 ();
   cond_exec_if #(.CNT_W(16)) if1 ();

   assign if0.id_valid      = id_valid;
   assign if0.id_cond       = id_cond;
   assign if0.id_set_flags  = id_set_flags;
   assign if0.exe_alu_flags = exe_alu_flags;
   assign if0.freeze        = freeze;
   assign if0.flush         = flush;
   assign if1.id_valid      = id_valid;
   assign if1.id_cond       = id_cond;
   assign if1.id_set_flags  = id_set_flags;
   assign if1.exe_alu_flags = exe_alu_flags;
   assign if1.freeze        = freeze;
   assign if1.flush         = flush;

   cond_exec_sequencer #(.FWD_EN(0), .CNT_W(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   cond_exec_sequencer #(.FWD_EN(1), .CNT_W(16)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state, one entry per instance.
   localparam bit FWDS [2] = '{1'b0, 1'b1};
   localparam int CMAX [2] = '{15, 65535};
   logic [3:0] m_st  [2];
   bit         m_ex  [2];
   bit         m_sf  [2];
   int         m_cnt [2];

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      {n, z, cy, v} = f;
      if (c == 4'd14) return 1'b1;
      if (c == 4'd15) return 1'b0;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy & ~z;
         3'd5:    base = (n == v);
         default: base = ~z & (n == v);
      endcase
      return base ^ c[0];
   endfunction

   task automatic check(input string tag, input int d,
                        input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d]  = 4'b0000;
         m_ex[d]  = 1'b0;
         m_sf[d]  = 1'b0;
         m_cnt[d] = 0;
      end
   endtask

   // Compare every output of both instances against the model, then clock.
   task automatic step();
      logic [3:0] n_st [2];
      bit         n_ex [2];
      bit         n_sf [2];
      int         n_cnt [2];
      #1;
      if (!rst) model_reset();
      for (int d = 0; d < 2; d++) begin
         logic [3:0]  src;
         bit          pass, stl, idx, wr;
         logic [31:0] o_idx, o_stl, o_ex, o_sf, o_st, o_cnt;
         wr   = m_ex[d] && m_sf[d];
         src  = (FWDS[d] && wr) ? exe_alu_flags : m_st[d];
         pass = cond_ok(id_cond, src);
         stl  = !FWDS[d] && id_valid && !flush && (id_cond != 4'd14) && wr;
         idx  = id_valid && pass && !flush && !stl && !freeze;
         if (d == 0) begin
            o_idx = 32'(if0.id_exec);  o_stl = 32'(if0.flag_stall);
            o_ex  = 32'(if0.exe_exec); o_sf  = 32'(if0.exe_set_flags);
            o_st  = 32'(if0.status);   o_cnt = 32'(if0.stall_cnt);
         end else begin
            o_idx = 32'(if1.id_exec);  o_stl = 32'(if1.flag_stall);
            o_ex  = 32'(if1.exe_exec); o_sf  = 32'(if1.exe_set_flags);
            o_st  = 32'(if1.status);   o_cnt = 32'(if1.stall_cnt);
         end
         check("id_exec", d, o_idx, 32'(idx));
         check("flag_stall", d, o_stl, 32'(stl));
         check("exe_exec", d, o_ex, 32'(m_ex[d]));
         check("exe_set_flags", d, o_sf, 32'(m_sf[d]));
         check("status", d, o_st, 32'(m_st[d]));
         check("stall_cnt", d, o_cnt, 32'(m_cnt[d]));
         n_st[d] = m_st[d]; n_ex[d] = m_ex[d]; n_sf[d] = m_sf[d];
         n_cnt[d] = m_cnt[d];
         if (!freeze) begin
            if (wr) n_st[d] = exe_alu_flags;
            n_ex[d] = !(flush || stl) && id_valid && pass;
            n_sf[d] = n_ex[d] && id_set_flags;
            if (stl && m_cnt[d] < CMAX[d]) n_cnt[d] = m_cnt[d] + 1;
         end
      end
      @(posedge clk);
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            m_st[d] = n_st[d]; m_ex[d] = n_ex[d];
            m_sf[d] = n_sf[d]; m_cnt[d] = n_cnt[d];
         end
      end
      #1;
   endtask

   task automatic drive(input bit v, input logic [3:0] c, input bit s,
                        input logic [3:0] alu, input bit fz, input bit fl);
      id_valid = v; id_cond = c; id_set_flags = s;
      exe_alu_flags = alu; freeze = fz; flush = fl;
   endtask

   logic [3:0] saved_st;
   int         saved_cnt;

   initial begin
      model_reset();
      rst = 1'b0;
      drive(0, 4'd0, 0, 4'd0, 0, 0);

      // Reset held while inputs toggle.
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'($urandom), 1, 4'($urandom), 0, 0);
         step();
      end
      #1;
      check("rst_status", 0, 32'(if0.status), 32'd0);
      check("rst_cnt", 0, 32'(if0.stall_cnt), 32'd0);
      check("rst_exe_exec", 1, 32'(if1.exe_exec), 32'd0);

      // Release; AL instruction issues and enters EXE.
      rst = 1'b1;
      drive(1, 4'd14, 1, 4'd0, 0, 0);
      #1;
      check("al_id_exec", 0, 32'(if0.id_exec), 32'd1);
      step();
      check("al_exe_exec", 0, 32'(if0.exe_exec), 32'd1);

      // BEQ behind the flag-setting AL instruction (EXE produces Z=1).
      drive(1, 4'd0, 0, 4'b0100, 0, 0);
      #1;
      check("haz_stall", 0, 32'(if0.flag_stall), 32'd1);
      check("fwd_no_stall", 1, 32'(if1.flag_stall), 32'd0);
      check("fwd_id_exec", 1, 32'(if1.id_exec), 32'd1);
      step();
      drive(1, 4'd0, 0, 4'b0000, 0, 0);
      #1;
      check("haz_bubble", 0, 32'(if0.exe_exec), 32'd0);
      check("haz_status", 0, 32'(if0.status), 32'h4);
      check("haz_id_exec", 0, 32'(if0.id_exec), 32'd1);
      check("haz_cnt", 0, 32'(if0.stall_cnt), 32'd1);
      step();

      // Condition table: load status through an S instruction, then sweep.
      for (int s = 0; s < 16; s++) begin
         drive(1, 4'd14, 1, 4'd0, 0, 0);
         step();
         drive(0, 4'd0, 0, 4'(s), 0, 0);
         step();
         for (int c = 0; c < 16; c++) begin
            drive(1, 4'(c), 0, 4'($urandom), 0, 0);
            step();
         end
      end

      // Flush with a hazard present.
      drive(1, 4'd14, 1, 4'd0, 0, 0);
      step();
      drive(1, 4'd0, 0, 4'b1000, 0, 1);
      #1;
      check("flush_no_stall", 0, 32'(if0.flag_stall), 32'd0);
      step();
      drive(0, 4'd0, 0, 4'd0, 0, 0);
      #1;
      check("flush_bubble", 0, 32'(if0.exe_exec), 32'd0);
      check("flush_status", 0, 32'(if0.status), 32'h8);
      check("flush_status", 1, 32'(if1.status), 32'h8);
      step();

      // Freeze for three cycles with a flag producer in EXE.
      drive(1, 4'd14, 1, 4'd0, 0, 0);
      step();
      saved_st  = m_st[0];
      saved_cnt = m_cnt[0];
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'($urandom), 1, 4'($urandom), 1, i[0]);
         step();
      end
      check("freeze_status", 0, 32'(if0.status), 32'(saved_st));
      check("freeze_cnt", 0, 32'(if0.stall_cnt), 32'(saved_cnt));
      check("freeze_exe", 0, 32'(if0.exe_set_flags), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         drive($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
               4'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0);
         step();
      end

      // Saturation: 20 producer/consumer pairs from a cleared counter.
      rst = 1'b0;
      drive(0, 4'd0, 0, 4'd0, 0, 0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1, 4'd14, 1, 4'($urandom), 0, 0);
         step();
         drive(1, 4'($urandom_range(0, 13)), 0, 4'($urandom), 0, 0);
         step();
      end
      check("sat_cnt", 0, 32'(if0.stall_cnt), 32'd15);
      check("sat_fwd_cnt", 1, 32'(if1.stall_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
